limber_gnrl_ram1w1r: RTL and testbench

Parametrised simple dual-port RAM (one write port, one read port) for the Limber MCU general library, with per-byte write mask, registered read with configurable latency, valid/ready backpressure on the read side, and optional same-cycle write-to-read forwarding. It sits between bus-facing logic (ITCM/DTCM, FIFOs, register files) and the storage array. The block provides flow-controlled reads whose returned data is frozen at request acceptance.

---
 rtl/limber_gnrl_ram1w1r_pkg.sv | 12 +
 rtl/limber_gnrl_ram1w1r_pipe_stage.sv | 45 ++++
 rtl/limber_gnrl_ram1w1r.sv | 119 +++++++++++
 tb/tb_limber_gnrl_ram1w1r.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/limber_gnrl_ram1w1r_pkg.sv
// Shared limber_gnrl constants: byte width and the legal read-latency range.
package limber_gnrl_ram1w1r_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/limber_gnrl_ram1w1r_pipe_stage.sv
// One valid/ready register slice with a DW-wide payload; valid and data reset to 0.
module limber_gnrl_pipe_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Load when empty or when downstream drains us this cycle.
  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/limber_gnrl_ram1w1r.sv
// Simple dual-port RAM: byte-masked write port, flow-controlled registered read
// port with RD_LAT stages and optional same-cycle write-to-read forwarding.
module limber_gnrl_ram1w1r
  import limber_gnrl_ram1w1r_pkg::*;
#(
  parameter int unsigned DP           = 64,
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 6,
  parameter int unsigned MW           = DW / 8,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned BYPASS       = 1,
  parameter int unsigned FORCE_X2ZERO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [MW-1:0] wr_mask,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [DW-1:0] rd_data
);

  if (!rd_lat_legal(RD_LAT) || ((DW % BYTE_W) != 0) || (MW != DW / BYTE_W)
      || ((2 ** AW) < DP)) begin : g_bad_cfg
    $fatal(1, "limber_gnrl_ram1w1r: illegal parameters (RD_LAT/DW/MW/AW)");
  end

  localparam logic [AW:0] DP_A = (AW+1)'(DP);

  logic [DW-1:0] mem [DP];
  logic          wr_in_rng, rd_in_rng, bypass_hit;
  logic [DW-1:0] arr_raw, arr_rd, s1_payload;

  assign wr_in_rng = ({1'b0, wr_addr} < DP_A);
  assign rd_in_rng = ({1'b0, rd_addr} < DP_A);

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_rng) begin
      for (int unsigned i = 0; i < MW; i++) begin
        if (wr_mask[i]) begin
          mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign arr_raw = rd_in_rng ? mem[rd_addr] : '0;

  if (FORCE_X2ZERO != 0) begin : g_x2zero
    always_comb begin
      arr_rd = '0;
      for (int unsigned i = 0; i < DW; i++) begin
        arr_rd[i] = (arr_raw[i] === 1'b1);
      end
    end
  end else begin : g_no_x2zero
    assign arr_rd = arr_raw;
  end

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [MW-1:0] mask);
    logic [DW-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MW; i++) begin
      if (mask[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  assign bypass_hit = (BYPASS != 0) && wr_en && wr_in_rng && (wr_addr == rd_addr);
  assign s1_payload = bypass_hit ? merge_bytes(arr_rd, wr_data, wr_mask) : arr_rd;

  // Each stage owns its link signals so the ready chain is not one shared vector.
  for (genvar k = 0; k < RD_LAT; k++) begin : g_stage
    logic          in_vld, in_rdy, out_vld, out_rdy;
    logic [DW-1:0] in_dat, out_dat;

    if (k == 0) begin : g_head
      assign in_vld = rd_req_valid;
      assign in_dat = s1_payload;
    end else begin : g_link
      assign in_vld = g_stage[k-1].out_vld;
      assign in_dat = g_stage[k-1].out_dat;
    end

    if (k == RD_LAT - 1) begin : g_tail
      assign out_rdy = rd_rsp_ready;
    end else begin : g_fwd
      assign out_rdy = g_stage[k+1].in_rdy;
    end

    limber_gnrl_pipe_stage #(
      .DW (DW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_vld),
      .in_ready_o  (in_rdy),
      .in_data_i   (in_dat),
      .out_valid_o (out_vld),
      .out_ready_i (out_rdy),
      .out_data_o  (out_dat)
    );
  end

  assign rd_req_ready = g_stage[0].in_rdy;
  assign rd_rsp_valid = g_stage[RD_LAT-1].out_vld;
  assign rd_data      = g_stage[RD_LAT-1].out_dat;

endmodule

// File: tb/tb_limber_gnrl_ram1w1r.sv
// Directed bench: three RAM configurations share one stimulus stream;
// each check targets the instance whose parameters it exercises.
module tb_limber_gnrl_ram1w1r;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rd_req_valid;
  logic [5:0]  rd_addr;
  logic        rd_rsp_ready;

  logic        a_req_ready, a_rsp_valid;
  logic [31:0] a_data;
  logic        b_req_ready, b_rsp_valid;
  logic [31:0] b_data;
  logic        c_req_ready, c_rsp_valid;
  logic [31:0] c_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: DP=48, RD_LAT=1, bypass on
  limber_gnrl_ram1w1r #(.DP(48), .DW(32), .AW(6), .RD_LAT(1), .BYPASS(1), .FORCE_X2ZERO(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_req_valid(rd_req_valid), .rd_req_ready(a_req_ready),
    .rd_addr(rd_addr), .rd_rsp_valid(a_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_data(a_data));

  // b: DP=64, RD_LAT=1, bypass off
  limber_gnrl_ram1w1r #(.DP(64), .DW(32), .AW(6), .RD_LAT(1), .BYPASS(0), .FORCE_X2ZERO(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_req_valid(rd_req_valid), .rd_req_ready(b_req_ready),
    .rd_addr(rd_addr), .rd_rsp_valid(b_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_data(b_data));

  // c: DP=64, RD_LAT=2, bypass on
  limber_gnrl_ram1w1r #(.DP(64), .DW(32), .AW(6), .RD_LAT(2), .BYPASS(1), .FORCE_X2ZERO(0)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_req_valid(rd_req_valid), .rd_req_ready(c_req_ready),
    .rd_addr(rd_addr), .rd_rsp_valid(c_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_data(c_data));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    wr_mask = '0;
  endtask

  // Read address a (optionally with a same-cycle write to a); checks a/b after
  // one edge and c after two edges, with the consumer always ready.
  task automatic read3(input string tag, input logic [5:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    rd_rsp_ready = 1'b1;
    rd_req_valid = 1'b1;
    rd_addr      = a;
    wr_en        = we;
    wr_addr      = a;
    wr_data      = wd;
    wr_mask      = wm;
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    wr_en        = 1'b0;
    wr_mask      = '0;
    check({tag, "_a_vld"}, a_rsp_valid, 1'b1);
    check({tag, "_a_dat"}, a_data, ea);
    check({tag, "_b_vld"}, b_rsp_valid, 1'b1);
    check({tag, "_b_dat"}, b_data, eb);
    check({tag, "_c_lat"}, c_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_a_done"}, a_rsp_valid, 1'b0);
    check({tag, "_c_vld"}, c_rsp_valid, 1'b1);
    check({tag, "_c_dat"}, c_data, ec);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          outst, idx, resp;
    logic        drop_seen, have_prev, accept, respond;
    logic [31:0] prev;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_rsp_ready = 1'b1;
    #12;
    check("rst_a_vld", a_rsp_valid, 1'b0);
    check("rst_a_dat", a_data, 32'h0);
    check("rst_a_rdy", a_req_ready, 1'b1);
    check("rst_c_vld", c_rsp_valid, 1'b0);
    check("rst_c_dat", c_data, 32'h0);
    check("rst_c_rdy", c_req_ready, 1'b1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(6'd5, 32'hDEADBEEF, 4'hF);
    read3("basic", 6'd5, 1'b0, '0, '0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

    do_write(6'd3, 32'h11223344, 4'hF);
    do_write(6'd3, 32'hAABBCCDD, 4'b0101);
    read3("bmask", 6'd3, 1'b0, '0, '0, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
    do_write(6'd3, 32'hFFFFFFFF, 4'h0);
    read3("mask0", 6'd3, 1'b0, '0, '0, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    do_write(6'd7, 32'h0, 4'hF);
    read3("byp", 6'd7, 1'b1, 32'h12345678, 4'hF, 32'h12345678, 32'h00000000, 32'h12345678);
    read3("byp_next", 6'd7, 1'b0, '0, '0, 32'h12345678, 32'h12345678, 32'h12345678);
    read3("byp_merge", 6'd7, 1'b1, 32'hAABBCCDD, 4'b0011, 32'h1234CCDD, 32'h12345678, 32'h1234CCDD);
    read3("post_merge", 6'd7, 1'b0, '0, '0, 32'h1234CCDD, 32'h1234CCDD, 32'h1234CCDD);

    do_write(6'd2, 32'h02020202, 4'hF);
    do_write(6'd18, 32'h18181818, 4'hF);
    do_write(6'd50, 32'hCAFEF00D, 4'hF);
    read3("oor", 6'd50, 1'b0, '0, '0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    read3("oor_a18", 6'd18, 1'b0, '0, '0, 32'h18181818, 32'h18181818, 32'h18181818);
    read3("oor_a2", 6'd2, 1'b0, '0, '0, 32'h02020202, 32'h02020202, 32'h02020202);

    // frozen data: stall a read of 2 and overwrite 2 underneath it
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr      = 6'd2;
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    do_write(6'd2, 32'h99999999, 4'hF);
    check("frz_a_vld", a_rsp_valid, 1'b1);
    check("frz_a_dat", a_data, 32'h02020202);
    check("frz_a_rdy", a_req_ready, 1'b0);
    check("frz_c_dat", c_data, 32'h02020202);
    @(posedge clk); #1;
    check("frz_hold", a_data, 32'h02020202);
    rd_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("frz_rel", a_rsp_valid, 1'b0);
    @(posedge clk); #1;
    read3("frz_new", 6'd2, 1'b0, '0, '0, 32'h99999999, 32'h99999999, 32'h99999999);

    // backpressure on the two-stage instance
    for (int unsigned i = 0; i < 8; i++) do_write(6'(i), 32'hA0000000 + i, 4'hF);
    outst = 0; idx = 0; resp = 0; drop_seen = 1'b0; have_prev = 1'b0; prev = '0;
    for (int unsigned cyc = 0; cyc < 40; cyc++) begin
      rd_rsp_ready = !(cyc >= 4 && cyc <= 6);
      rd_req_valid = (idx < 8);
      rd_addr      = 6'(idx);
      @(negedge clk);
      check("bp_ready", c_req_ready, (outst < 2) || rd_rsp_ready);
      if (have_prev) check("bp_stable", c_data, prev);
      if (!c_req_ready && rd_req_valid) drop_seen = 1'b1;
      accept  = rd_req_valid && c_req_ready;
      respond = c_rsp_valid && rd_rsp_ready;
      if (respond) begin
        check("bp_data", c_data, 32'hA0000000 + 32'(resp));
        resp++;
      end
      have_prev = c_rsp_valid && !rd_rsp_ready;
      prev      = c_data;
      @(posedge clk); #1;
      if (accept)  begin idx++;  outst++; end
      if (respond) outst--;
      if (resp == 8 && idx == 8) break;
    end
    rd_req_valid = 1'b0;
    check("bp_count", 32'(resp), 32'd8);
    check("bp_drop", drop_seen, 1'b1);
    check("bp_nodup", c_rsp_valid, 1'b0);

    // reset with two reads in flight
    do_write(6'd9, 32'h5A5AA5A5, 4'hF);
    do_write(6'd10, 32'h10101010, 4'hF);
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr      = 6'd9;
    @(posedge clk); #1;
    rd_addr = 6'd10;
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    check("rst_pre_vld", c_rsp_valid, 1'b1);
    check("rst_pre_rdy", c_req_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_c_vld", c_rsp_valid, 1'b0);
    check("rst_mid_c_dat", c_data, 32'h0);
    check("rst_mid_c_rdy", c_req_ready, 1'b1);
    check("rst_mid_a_vld", a_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_rdy", c_req_ready, 1'b1);
    rst_n = 1'b1;
    rd_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_post_vld", c_rsp_valid, 1'b0);
    read3("rst_after", 6'd9, 1'b0, '0, '0, 32'h5A5AA5A5, 32'h5A5AA5A5, 32'h5A5AA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
